// File: rtl/halt_dump_tx.sv
// Streams a framed snapshot (header, CPU registers, RAM, checksum) over a byte-wide
// valid/ready channel once per rising edge of the CPU halted flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | armed, waiting for a halted rising edge
// S_HDR    | presenting the frame header byte
// S_REGS   | presenting snapshot register bytes A..Temp
// S_MEM_RD | one-cycle RAM read strobe for the current address
// S_MEM_TX | presenting the RAM byte returned by the read
// S_CSUM   | presenting the running checksum
// S_DONE   | frame finished, waiting for halted to drop before re-arming
module halt_dump_tx #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          MEM_DEPTH  = 256,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halted,
    input  logic [63:0]           regs,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REGS,
        S_MEM_RD,
        S_MEM_TX,
        S_CSUM,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    halted_q, halted_d;
    logic [63:0]             snap_q, snap_d;
    logic [7:0]              csum_q, csum_d;
    logic [2:0]              idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              mem_byte_q, mem_byte_d;
    logic                    mem_first_q, mem_first_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            halted_q    <= 1'b1;
            snap_q      <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            mem_byte_q  <= '0;
            mem_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            snap_q      <= snap_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            mem_byte_q  <= mem_byte_d;
            mem_first_q <= mem_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        halted_d    = halted;
        snap_d      = snap_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        mem_byte_d  = mem_byte_q;
        mem_first_d = mem_first_q;

        tx_data  = 8'h00;
        tx_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = addr_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (halted && !halted_q) begin
                    snap_d  = regs;
                    csum_d  = 8'h00;
                    state_d = S_HDR;
                end
            end

            S_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    idx_d   = 3'd0;
                    state_d = S_REGS;
                end
            end

            S_REGS: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = snap_q[{idx_q, 3'b000} +: 8];
                if (tx_ready) begin
                    csum_d = csum_q + tx_data;
                    if (idx_q == 3'd7) begin
                        addr_d  = '0;
                        state_d = S_MEM_RD;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_MEM_RD: begin
                busy        = 1'b1;
                mem_rd      = 1'b1;
                mem_first_d = 1'b1;
                state_d     = S_MEM_TX;
            end

            S_MEM_TX: begin
                busy        = 1'b1;
                tx_valid    = 1'b1;
                // RAM output is only trusted in the cycle after the strobe; hold our own copy after that.
                tx_data     = mem_first_q ? mem_data : mem_byte_q;
                mem_byte_d  = tx_data;
                mem_first_d = 1'b0;
                if (tx_ready) begin
                    csum_d = csum_q + tx_data;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_CSUM;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_MEM_RD;
                    end
                end
            end

            S_CSUM: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done = 1'b1;
                if (!halted) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/halt_dump_tx.md
Name: halt_dump_tx

Overview:
- Hardware counterpart of image loading: when the CPU halts, streams a snapshot of the CPU registers and the full RAM contents out over a byte-wide valid/ready channel.
- Sits at machine level beside the CPU and RAM.
- Uses the CPU `halted` flag, the flattened register file, and a dedicated RAM read port.
- The downstream consumer (UART TX, debug bridge) sees one framed dump per halt.

Parameters:
ADDR_WIDTH, 8, RAM address width.
MEM_DEPTH, 256, number of RAM bytes dumped (addresses 0..MEM_DEPTH-1, MEM_DEPTH <= 2**ADDR_WIDTH).
HEADER, 8'hA5, frame start byte.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
halted  input  1  CPU halted flag, level.
regs  input  64  register snapshot source, byte order {Temp,G,F,E,D,C,B,A}; A in bits [7:0].
mem_addr  output  ADDR_WIDTH  RAM read address.
mem_rd  output  1  RAM read strobe; data valid on mem_data one cycle later.
mem_data  input  8  RAM read data.
tx_data  output  8  stream byte.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  consumer accepts byte when tx_valid && tx_ready at a rising edge.
busy  output  1  dump in progress.
done  output  1  dump complete, held until re-armed.

Behaviour:
- Reset (reset low, async): state IDLE. tx_data=0, tx_valid=0, mem_addr=0, mem_rd=0, busy=0, done=0. The checksum and the halted edge register clear; the edge register clears to 1, so a halted already high at reset release does not trigger.
- Trigger: halted sampled 1 while its previous sample was 0.
  - On that edge: regs latched into an internal snapshot, checksum cleared, state HDR, busy=1.
- Frame order: HEADER, A, B, C, D, E, F, G, Temp, mem[0]..mem[MEM_DEPTH-1], CSUM.
  - CSUM = 8-bit wraparound sum of every byte after HEADER; HEADER is excluded.
- States:
  - IDLE: wait for trigger. In IDLE and DONE, busy=0 and tx_valid=0.
  - HDR: tx_valid=1, tx_data=HEADER; on accept -> REGS, index=0.
  - REGS: tx_data = snapshot byte[index]; on accept, add it to the checksum; after index 7 -> MEM_RD, addr=0.
  - MEM_RD: one cycle with mem_rd=1 and mem_addr=addr, tx_valid=0 -> MEM_TX.
  - MEM_TX: mem_data is captured into tx_data on entry, and tx_valid=1 is held with stable data until accept.
    - On accept: add to the checksum. If addr == MEM_DEPTH-1 -> CSUM; else addr+1 -> MEM_RD.
  - CSUM: tx_data = checksum; on accept -> DONE. done=1, busy=0.
  - DONE: done stays 1 while halted=1. When halted is sampled 0 -> IDLE, done=0 (re-armed).
- Handshake rules:
  - tx_data is stable while tx_valid=1 && tx_ready=0.
  - tx_valid never drops without an accept.
  - tx_ready is ignored when tx_valid=0.
- Throughput with tx_ready held 1:
  - Header and register bytes: one per cycle.
  - RAM bytes: one per 2 cycles.
  - Total cycles from the trigger edge to the CSUM accept = 1 + 8 + 2*MEM_DEPTH + 1.
- Boundaries:
  - halted falling mid-dump: the dump continues to completion on the snapshot. DONE then exits to IDLE on the next cycle.
  - halted re-rising while busy: ignored; no restart, no second frame.
  - mem_addr does not wrap past MEM_DEPTH-1.
  - Checksum wraps modulo 256.
  - mem_rd is asserted only in MEM_RD. mem_addr holds its last value otherwise.
  - Reset asserted mid-dump: immediate abort to the reset values; no partial CSUM is emitted.

Test Plan:
- Basic dump: MEM_DEPTH=16, mem[i]=i, regs A..Temp=01..08, tx_ready=1, raise halted.
  - Expect bytes A5,01..08,00..0F,9C (0x24+0x78).
  - busy high for 1+8+32+1=42 cycles; done=1 after.
- Backpressure: same frame, tx_ready toggling pseudo-randomly.
  - Expect an identical byte sequence.
  - tx_data stable whenever valid && !ready.
  - No byte duplicated or skipped.
- Checksum wrap: all RAM=FF, regs=FF, MEM_DEPTH=16.
  - CSUM = (24*0xFF) mod 256 = 0xE8.
- Re-arm: after done, drop halted, then raise it again with changed regs (A=55).
  - Expect a second full frame with A=55 and done cleared between frames.
  - Holding halted high without a new rising edge produces no frame.
- Mid-dump events:
  - Drop halted during the memory phase: the frame completes, then IDLE.
  - Assert reset (low) during the memory phase: all outputs read 0 within the same cycle, no CSUM is emitted, and the next halted rising edge yields a full, correct frame.
